// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and helpers for the UART blocks
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - divide-by-DIV tick generator with synchronous restart
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  generate
    if (DIV < 1) begin : g_div_chk
      $error("uart_baud_tick: DIV must be at least 1");
    end
  endgenerate

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (restart_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with majority vote, parity/framing
// error reporting and a valid/ready output holding register with overrun detection.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  line,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int DIV = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_WIDTH);
  localparam logic [SW-1:0] S_A     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_C     = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END   = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          ODD_PAR  = (PARITY == PARITY_ODD);

  generate
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_chk
      $error("uart_rx_os: illegal parameter combination");
    end
  endgenerate

  logic                  sync1_q, sync2_q, prev_q;
  rx_state_e             state_q;
  logic [SW-1:0]         samp_cnt_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  stop_cnt_q;
  logic [1:0]            samp_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_err_q, frm_err_q, done_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q, parity_err_q, frame_err_q, overrun_q;

  logic start_det, tick, bit_val, decide, bit_end, par_exp;

  assign start_det = (state_q == ST_IDLE) && prev_q && !sync2_q;
  assign bit_val   = maj3(samp_q[0], samp_q[1], sync2_q);
  assign decide    = tick && (samp_cnt_q == S_C);
  assign bit_end   = tick && (samp_cnt_q == S_END);
  assign par_exp   = (^shift_q) ^ ODD_PAR;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .restart_i(start_det),
    .tick_o   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= ST_IDLE;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      samp_q     <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sync1_q <= line;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      done_q  <= 1'b0;
      if (tick) begin
        samp_cnt_q <= (samp_cnt_q == S_END) ? '0 : samp_cnt_q + 1'b1;
        if (samp_cnt_q == S_A) samp_q[0] <= sync2_q;
        if (samp_cnt_q == S_B) samp_q[1] <= sync2_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_det) begin
            state_q    <= ST_START;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
          end
        end
        ST_START: begin
          if (decide && bit_val) state_q <= ST_IDLE;
          else if (bit_end)      state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (decide) shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
          if (bit_end) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (decide && (bit_val != par_exp)) par_err_q <= 1'b1;
          if (bit_end) state_q <= ST_STOP;
        end
        ST_STOP: begin
          // Leave on the last stop decision so a start bit right behind it is seen.
          if (decide) begin
            if (!bit_val) frm_err_q <= 1'b1;
            if (stop_cnt_q == LAST_STOP) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end else if (bit_end) begin
            stop_cnt_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_q    <= shift_q;
        parity_err_q <= par_err_q;
        frame_err_q  <= frm_err_q;
        rx_valid_q   <= 1'b1;
        overrun_q    <= 1'b0;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
